// File: rtl/lsu_gen2.sv
// lsu_gen2: per-thread load/store unit with one read/write FSM,
// a DONE state held until UPDATE and an optional request watchdog.
module lsu_gen2 #(
    parameter int DATA_BITS      = 8,
    parameter int ADDR_BITS      = 8,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [2:0]           core_state,
    input  logic                 decoded_mem_read_enable,
    input  logic                 decoded_mem_write_enable,
    input  logic [DATA_BITS-1:0] rs,
    input  logic [DATA_BITS-1:0] rt,
    output logic                 mem_read_valid,
    output logic [ADDR_BITS-1:0] mem_read_address,
    input  logic                 mem_read_ready,
    input  logic [DATA_BITS-1:0] mem_read_data,
    output logic                 mem_write_valid,
    output logic [ADDR_BITS-1:0] mem_write_address,
    output logic [DATA_BITS-1:0] mem_write_data,
    input  logic                 mem_write_ready,
    output logic [1:0]           lsu_state,
    output logic [DATA_BITS-1:0] lsu_out,
    output logic                 lsu_error
);

    localparam logic [2:0] REQUEST = 3'b011;
    localparam logic [2:0] UPDATE  = 3'b110;

    localparam int CW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int LIM = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CW-1:0] CNT_LIM = CW'(LIM);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        REQUESTING = 2'd1,
        WAITING    = 2'd2,
        DONE       = 2'd3
    } state_t;

    state_t               state;
    logic                 is_read;
    logic [ADDR_BITS-1:0] addr_q;
    logic [DATA_BITS-1:0] data_q;
    logic [CW-1:0]        cnt;
    logic [ADDR_BITS-1:0] addr_map;
    logic                 hit_ready;
    logic                 unused_rs;

    // Narrow addresses take the low bits; wide ones zero-extend rs.
    if (ADDR_BITS <= DATA_BITS) begin : g_trunc
        assign addr_map = rs[ADDR_BITS-1:0];
    end else begin : g_zext
        assign addr_map = {{(ADDR_BITS - DATA_BITS){1'b0}}, rs};
    end

    assign unused_rs = ^rs;
    assign hit_ready = is_read ? mem_read_ready : mem_write_ready;
    assign lsu_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            is_read           <= 1'b0;
            addr_q            <= '0;
            data_q            <= '0;
            cnt               <= '0;
            mem_read_valid    <= 1'b0;
            mem_read_address  <= '0;
            mem_write_valid   <= 1'b0;
            mem_write_address <= '0;
            mem_write_data    <= '0;
            lsu_out           <= '0;
            lsu_error         <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (enable && core_state == REQUEST &&
                        (decoded_mem_read_enable || decoded_mem_write_enable)) begin
                        is_read   <= decoded_mem_read_enable;
                        addr_q    <= addr_map;
                        data_q    <= rt;
                        lsu_error <= 1'b0;
                        state     <= REQUESTING;
                    end
                end
                REQUESTING: begin
                    cnt <= '0;
                    if (is_read) begin
                        mem_read_valid   <= 1'b1;
                        mem_read_address <= addr_q;
                    end else begin
                        mem_write_valid   <= 1'b1;
                        mem_write_address <= addr_q;
                        mem_write_data    <= data_q;
                    end
                    state <= WAITING;
                end
                WAITING: begin
                    // A ready on the threshold cycle still completes normally.
                    if (hit_ready) begin
                        mem_read_valid  <= 1'b0;
                        mem_write_valid <= 1'b0;
                        if (is_read) lsu_out <= mem_read_data;
                        state <= DONE;
                    end else if (TIMEOUT_CYCLES > 0 && cnt == CNT_LIM) begin
                        mem_read_valid  <= 1'b0;
                        mem_write_valid <= 1'b0;
                        lsu_error       <= 1'b1;
                        if (is_read) lsu_out <= '1;
                        state <= DONE;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (core_state == UPDATE) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_gen2.sv
// tb_lsu_gen2: randomized scoreboard bench for lsu_gen2 with watchdog
// on/off instances plus two address-width instances.
module tb_lsu_gen2;

    localparam logic [2:0] REQ = 3'b011;
    localparam logic [2:0] UPD = 3'b110;
    localparam logic [2:0] OTH = 3'b000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, enable, rd_en, wr_en;
    logic [2:0] core_state;
    logic [7:0] rs, rt, mem_read_data;
    logic       mem_read_ready, mem_write_ready;

    logic [1:0]      rv, wv, le;
    logic [1:0][7:0] ra, wa, wd, lo;
    logic [1:0][1:0] st;

    int checks = 0;
    int failures = 0;

    lsu_gen2 #(.DATA_BITS(8), .ADDR_BITS(8), .TIMEOUT_CYCLES(4)) u_t4 (
        .clk(clk), .reset(reset), .enable(enable), .core_state(core_state),
        .decoded_mem_read_enable(rd_en), .decoded_mem_write_enable(wr_en),
        .rs(rs), .rt(rt),
        .mem_read_valid(rv[0]), .mem_read_address(ra[0]),
        .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
        .mem_write_valid(wv[0]), .mem_write_address(wa[0]),
        .mem_write_data(wd[0]), .mem_write_ready(mem_write_ready),
        .lsu_state(st[0]), .lsu_out(lo[0]), .lsu_error(le[0])
    );

    lsu_gen2 #(.DATA_BITS(8), .ADDR_BITS(8), .TIMEOUT_CYCLES(0)) u_t0 (
        .clk(clk), .reset(reset), .enable(enable), .core_state(core_state),
        .decoded_mem_read_enable(rd_en), .decoded_mem_write_enable(wr_en),
        .rs(rs), .rt(rt),
        .mem_read_valid(rv[1]), .mem_read_address(ra[1]),
        .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
        .mem_write_valid(wv[1]), .mem_write_address(wa[1]),
        .mem_write_data(wd[1]), .mem_write_ready(mem_write_ready),
        .lsu_state(st[1]), .lsu_out(lo[1]), .lsu_error(le[1])
    );

    logic [2:0]  w_core;
    logic        w_rd, w_ready;
    logic [15:0] a_rs;
    logic [7:0]  b_rs;
    logic        a_rv, a_wv, a_le, b_rv, b_wv, b_le;
    logic [11:0] a_ra, a_wa;
    logic [9:0]  b_ra, b_wa;
    logic [15:0] a_wd, a_lo;
    logic [7:0]  b_wd, b_lo;
    logic [1:0]  a_st, b_st;

    lsu_gen2 #(.DATA_BITS(16), .ADDR_BITS(12), .TIMEOUT_CYCLES(0)) u_a (
        .clk(clk), .reset(reset), .enable(1'b1), .core_state(w_core),
        .decoded_mem_read_enable(w_rd), .decoded_mem_write_enable(1'b0),
        .rs(a_rs), .rt(16'h0000),
        .mem_read_valid(a_rv), .mem_read_address(a_ra),
        .mem_read_ready(w_ready), .mem_read_data(16'h1234),
        .mem_write_valid(a_wv), .mem_write_address(a_wa),
        .mem_write_data(a_wd), .mem_write_ready(1'b0),
        .lsu_state(a_st), .lsu_out(a_lo), .lsu_error(a_le)
    );

    lsu_gen2 #(.DATA_BITS(8), .ADDR_BITS(10), .TIMEOUT_CYCLES(0)) u_b (
        .clk(clk), .reset(reset), .enable(1'b1), .core_state(w_core),
        .decoded_mem_read_enable(w_rd), .decoded_mem_write_enable(1'b0),
        .rs(b_rs), .rt(8'h00),
        .mem_read_valid(b_rv), .mem_read_address(b_ra),
        .mem_read_ready(w_ready), .mem_read_data(8'h56),
        .mem_write_valid(b_wv), .mem_write_address(b_wa),
        .mem_write_data(b_wd), .mem_write_ready(1'b0),
        .lsu_state(b_st), .lsu_out(b_lo), .lsu_error(b_le)
    );

    typedef struct {
        logic       rd;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         vcyc;
        logic [7:0] out;
        logic       err;
    } exp_t;

    exp_t       q4[$];
    exp_t       q0[$];
    logic [7:0] model_out [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: tracks each valid window and scores every DONE entry.
    logic [1:0] pst [2];
    int         vc [2];
    logic [7:0] fa [2];
    logic [7:0] fd [2];
    logic       srd [2], swr [2], unst [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            pst[i] = 2'd0; vc[i] = 0; srd[i] = 0; swr[i] = 0; unst[i] = 0;
            fa[i] = 8'h00; fd[i] = 8'h00;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (st[i] == 2'd0) begin
                    vc[i] = 0; srd[i] = 0; swr[i] = 0; unst[i] = 0;
                end else if (rv[i] || wv[i]) begin
                    if (vc[i] == 0) begin
                        fa[i] = rv[i] ? ra[i] : wa[i];
                        fd[i] = wd[i];
                    end else if (fa[i] != (rv[i] ? ra[i] : wa[i]) || (wv[i] && fd[i] != wd[i])) begin
                        unst[i] = 1'b1;
                    end
                    vc[i]++;
                    srd[i] = srd[i] | rv[i];
                    swr[i] = swr[i] | wv[i];
                end
                if (st[i] == 2'd3 && pst[i] != 2'd3) begin
                    exp_t e;
                    int   qs;
                    qs = (i == 0) ? q4.size() : q0.size();
                    if (qs == 0) begin
                        chk($sformatf("sb_unexpected_done%0d", i), 1, 0);
                    end else begin
                        e = (i == 0) ? q4.pop_front() : q0.pop_front();
                        chk($sformatf("kind%0d", i), {srd[i], swr[i]}, {e.rd, ~e.rd});
                        chk($sformatf("addr%0d", i), fa[i], e.addr);
                        if (!e.rd) chk($sformatf("wdata%0d", i), fd[i], e.wdata);
                        chk($sformatf("valid_cycles%0d", i), vc[i], e.vcyc);
                        chk($sformatf("stable%0d", i), unst[i], 0);
                        chk($sformatf("valid_low%0d", i), rv[i] | wv[i], 0);
                        chk($sformatf("lsu_out%0d", i), lo[i], e.out);
                        chk($sformatf("lsu_error%0d", i), le[i], e.err);
                    end
                end
                pst[i] = st[i];
            end
        end
    end

    // Memory acks with ready k edges after valid rises; the other ready toggles randomly.
    task automatic do_txn(input logic en, input logic rd, input logic wr,
                          input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] rdat, input int k, input int hold);
        enable = en; core_state = REQ; rd_en = rd; wr_en = wr; rs = a; rt = d;
        if (!(en && (rd || wr))) begin
            tick();
            chk("idle_stay0", st[0], 0);
            chk("idle_stay1", st[1], 0);
            core_state = OTH; rd_en = 0; wr_en = 0;
            tick();
            chk("idle_still", {st[0], st[1]}, 0);
            return;
        end
        for (int i = 0; i < 2; i++) begin
            exp_t e;
            int   t;
            logic to;
            t = (i == 0) ? 4 : 0;
            to = (t > 0) && (k > t);
            e.rd = rd;
            e.addr = a;
            e.wdata = d;
            e.vcyc = to ? t : k;
            e.out = rd ? (to ? 8'hFF : rdat) : model_out[i];
            e.err = to;
            model_out[i] = e.out;
            if (i == 0) q4.push_back(e); else q0.push_back(e);
        end
        tick();
        chk("accept_clears_err", le[0], 0);
        chk("requesting", st[0], 2'd1);
        core_state = OTH; rd_en = 0; wr_en = 0;
        enable = 1'($urandom_range(0, 1));
        rs = 8'($urandom); rt = 8'($urandom);
        tick();
        for (int j = 1; j <= k; j++) begin
            if (rd) begin
                mem_write_ready = 1'($urandom_range(0, 1));
                mem_read_ready = (j == k);
                mem_read_data = (j == k) ? rdat : 8'($urandom);
            end else begin
                mem_read_ready = 1'($urandom_range(0, 1));
                mem_write_ready = (j == k);
            end
            tick();
            mem_read_ready = 0; mem_write_ready = 0;
            mem_read_data = 8'($urandom);
        end
        for (int c = 0; c < 20 && !(st[0] == 2'd3 && st[1] == 2'd3); c++) tick();
        chk("both_done", {st[0], st[1]}, 4'hF);
        repeat (hold) begin
            mem_read_ready = 1'($urandom_range(0, 1));
            mem_write_ready = 1'($urandom_range(0, 1));
            tick();
        end
        mem_read_ready = 0; mem_write_ready = 0;
        chk("done_held", {st[0], st[1]}, 4'hF);
        core_state = UPD;
        tick();
        core_state = OTH;
        chk("back_idle", {st[0], st[1]}, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset = 1; enable = 0; core_state = OTH; rd_en = 0; wr_en = 0;
        rs = 0; rt = 0; mem_read_ready = 0; mem_write_ready = 0; mem_read_data = 0;
        w_core = OTH; w_rd = 0; w_ready = 0; a_rs = 0; b_rs = 0;
        model_out[0] = 8'h00; model_out[1] = 8'h00;
        repeat (3) tick();
        reset = 0;
        tick();
        chk("rst_state", {st[0], st[1]}, 0);
        chk("rst_valids", {rv, wv}, 0);
        chk("rst_addr", {ra[0], wa[0], wd[0]}, 0);
        chk("rst_out", {lo[0], le[0]}, 0);

        w_core = REQ; w_rd = 1; a_rs = 16'hABCD; b_rs = 8'h81;
        tick();
        w_core = OTH; w_rd = 0; a_rs = 16'h0000; b_rs = 8'h00;
        tick();
        chk("w16_valid", {a_rv, b_rv}, 2'b11);
        chk("w16_addr", a_ra, 12'hBCD);
        chk("w10_addr", b_ra, 10'h081);
        w_ready = 1;
        tick();
        w_ready = 0;
        chk("w_done", {a_st, b_st}, 4'hF);
        chk("w16_out", a_lo, 16'h1234);
        chk("w10_out", b_lo, 8'h56);
        w_core = UPD;
        tick();
        w_core = OTH;
        chk("w_idle", {a_st, b_st}, 0);

        do_txn(1, 1, 0, 8'h2A, 8'h00, 8'h5C, 2, 2);
        do_txn(1, 0, 1, 8'h10, 8'hF3, 8'h00, 5, 1);
        do_txn(1, 1, 0, 8'h33, 8'h00, 8'h77, 7, 0);
        do_txn(1, 1, 0, 8'h44, 8'h00, 8'h99, 4, 0);
        do_txn(1, 1, 1, 8'h55, 8'hAA, 8'h3C, 1, 1);
        do_txn(0, 1, 0, 8'h66, 8'h00, 8'h00, 1, 0);

        enable = 1; core_state = REQ; rd_en = 1; rs = 8'h21;
        tick();
        core_state = OTH; rd_en = 0;
        repeat (2) tick();
        reset = 1;
        tick();
        reset = 0;
        chk("midrst_valid", {rv, wv}, 0);
        chk("midrst_state", {st[0], st[1]}, 0);
        mem_read_ready = 1; mem_read_data = 8'hEE;
        tick();
        mem_read_ready = 0;
        chk("midrst_ready_ignored", {st[0], st[1]}, 0);
        chk("midrst_out", {lo[0], lo[1]}, 0);
        model_out[0] = 8'h00; model_out[1] = 8'h00;

        for (int n = 0; n < 40; n++) begin
            do_txn(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                   8'($urandom), $urandom_range(1, 7), $urandom_range(0, 2));
        end
        tick();
        chk("sb_drained", q4.size() + q0.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_gen2.md
# lsu_gen2

Per-thread load/store unit with parametrised data and address widths, a single unified read/write state machine and an explicit DONE state held until the core's UPDATE stage. An optional watchdog timeout flags requests that memory never acknowledges. One instance sits beside each thread's ALU and register file. Each instance drives that thread's private channel into the memory controller, using a valid/ready request handshake.

## Interface
Parameters:
- DATA_BITS, 8, width of register operands, memory data and `lsu_out`.
- ADDR_BITS, 8, width of memory addresses.
- TIMEOUT_CYCLES, 0, number of WAITING cycles before a request is aborted; 0 disables the watchdog.

Ports:
- clk  in  1  Single clock; all state changes on its rising edge.
- reset  in  1  Synchronous, active-high reset.
- enable  in  1  Thread active; when 0 no new request is accepted.
- core_state  in  3  Core pipeline stage: REQUEST=3'b011, UPDATE=3'b110.
- decoded_mem_read_enable  in  1  Current instruction is LDR.
- decoded_mem_write_enable  in  1  Current instruction is STR.
- rs  in  DATA_BITS  Address operand.
- rt  in  DATA_BITS  Store data operand.
- mem_read_valid  out  1  Read request pending.
- mem_read_address  out  ADDR_BITS  Read address.
- mem_read_ready  in  1  Read acknowledged; data valid this cycle.
- mem_read_data  in  DATA_BITS  Returned read data.
- mem_write_valid  out  1  Write request pending.
- mem_write_address  out  ADDR_BITS  Write address.
- mem_write_data  out  DATA_BITS  Write data.
- mem_write_ready  in  1  Write acknowledged.
- lsu_state  out  2  IDLE=0, REQUESTING=1, WAITING=2, DONE=3.
- lsu_out  out  DATA_BITS  Last loaded value.
- lsu_error  out  1  Last request timed out.

## Operation
- **Address mapping:** address = `rs[ADDR_BITS-1:0]` when ADDR_BITS ≤ DATA_BITS, otherwise `rs` zero-extended.
- **IDLE:**
  - Go to REQUESTING when `enable` is 1, `core_state` is REQUEST, and either read or write enable is 1.
  - Latch the operation type, the address and `rt`.
  - If read and write enables are both 1, the read wins; the write is dropped.
  - Latching `lsu_error` clears it.
- **REQUESTING:** lasts exactly one cycle.
  - Raise `mem_read_valid` or `mem_write_valid`.
  - Drive the latched address, and the latched data for a write.
  - Clear the timeout counter.
  - Go to WAITING.
- **WAITING:**
  - Valid, address and data are held stable.
  - On the matching ready: drop valid, capture `mem_read_data` into `lsu_out` (reads only), go to DONE.
  - Otherwise the counter increments.
  - If TIMEOUT_CYCLES > 0 and the counter reaches TIMEOUT_CYCLES−1 without ready:
    - drop valid;
    - set `lsu_error`=1;
    - set `lsu_out` to all-ones for a read (unchanged for a write);
    - go to DONE.
  - Ready arriving in the same cycle as the timeout threshold wins: normal completion, no error.
- **DONE:**
  - Outputs are held.
  - Go to IDLE when `core_state` is UPDATE.
  - A new request cannot start until at least one cycle after leaving DONE, because IDLE is re-entered first.
- **Ignored inputs:**
  - Ready inputs are ignored outside WAITING.
  - The non-matching ready is ignored in WAITING.
- **`enable` deassertion:** if `enable` drops after a request is accepted, the transaction still completes; there is no abort path.
- **Counter width:** `$clog2(TIMEOUT_CYCLES+1)`, minimum 1 bit. It saturates and never wraps.

## Timing
- **Reset values:** `lsu_state`=IDLE, both valids 0, addresses 0, `mem_write_data` 0, `lsu_out` 0, `lsu_error` 0, counter 0.
- **Reset mid-transaction:** valids drop at that same edge; no completion is reported.
- **Request timing:** request sampled at edge N gives `lsu_state`=REQUESTING after N, and valid high from edge N+1.
- **Fastest completion:** ready sampled high at edge N+2 gives DONE and valid low after N+2, with `lsu_out` updated at N+2.
- **Minimum latency:** 3 cycles from request to DONE.
- **Timeout:** with TIMEOUT_CYCLES=T and no ready, DONE is entered T+1 cycles after REQUESTING.
- All outputs are registered; nothing combinational passes from inputs to outputs.

## Test plan
- **Read:** reset, then rs=0x2A, read_en=1, core_state=REQUEST; memory returns 0x5C with ready one cycle after valid.
  → `mem_read_address`=0x2A, valid high for 2 cycles, `lsu_out`=0x5C, DONE until UPDATE, then IDLE.
- **Write:** rs=0x10, rt=0xF3, write_en=1, ready delayed 4 cycles.
  → `mem_write_address`=0x10, data 0xF3, both held stable for all 5 valid cycles, DONE, `lsu_error`=0.
- **Timeout:** TIMEOUT_CYCLES=4, read with ready never asserted.
  → valid drops after 4 WAITING cycles, `lsu_error`=1, `lsu_out`=0xFF; the next request clears `lsu_error`.
- **Simultaneous events:**
  - read_en and write_en both 1 → only `mem_read_valid` rises.
  - ready on the timeout cycle → no error.
  - `enable`=0 with REQUEST → stays IDLE.
- **Reset mid-WAITING:** reset asserted during WAITING → valid 0 and IDLE after that edge; a later ready pulse is ignored.
- **Width parameters:** DATA_BITS=16, ADDR_BITS=12, rs=0xABCD → address 0xBCD; DATA_BITS=8, ADDR_BITS=10, rs=0x81 → address 0x081.
